// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared types for the ula operation sequencer:
//   ula_op_t     - ULAControl encodings understood by the external ula
//   seq_state_t  - sequencer FSM states
//   is_legal_op  - true for the ops the ula actually implements
// ---------------------------------------------------------------------------
package ula_pkg;

    typedef enum logic [2:0] {
        ULA_ADD = 3'b000,
        ULA_SUB = 3'b001,
        ULA_AND = 3'b010,
        ULA_OR  = 3'b011,
        ULA_SLT = 3'b101
    } ula_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    function automatic logic is_legal_op(ula_op_t op);
        case (op)
            ULA_ADD, ULA_SUB, ULA_AND, ULA_OR, ULA_SLT: return 1'b1;
            default:                                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ula_seq_regfile.sv
// ---------------------------------------------------------------------------
// ula_seq_regfile
// NREGS x DATA_W register file for the ula sequencer.
//   clk, reset_n        clock / async active-low clear (all entries -> 0)
//   rd1_addr/rd1_data   async read port A (feeds scrA)
//   rd2_addr/rd2_data   async read port B (feeds scrB)
//   wb_en/addr/data     result writeback port
//   pl_en/addr/data     host preload port
// Register 0 always reads 0 and ignores writes. The sequencer only enables
// writeback in EXEC and preload in IDLE, so the two write ports never
// collide.
// ---------------------------------------------------------------------------
module ula_seq_regfile #(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic [DATA_W-1:0] rd2_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              pl_en,
    input  logic [ADDR_W-1:0] pl_addr,
    input  logic [DATA_W-1:0] pl_data
);

    logic [NREGS-1:0][DATA_W-1:0] rf;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf <= '0;
        end else begin
            if (wb_en && (wb_addr != '0)) rf[wb_addr] <= wb_data;
            if (pl_en && (pl_addr != '0)) rf[pl_addr] <= pl_data;
        end
    end

    assign rd1_data = (rd1_addr == '0) ? '0 : rf[rd1_addr];
    assign rd2_data = (rd2_addr == '0) ? '0 : rf[rd2_addr];

endmodule

// File: rtl/ula_op_sequencer.sv
// ---------------------------------------------------------------------------
// ula_op_sequencer
// Initiator side of the ula interface. Accepts (op, rd, rs1, rs2) over
// valid/ready, reads operands from the internal register file, drives
// ULAControl/scrA/scrB to an external combinational ula, captures
// ULAResult/Z one cycle later, writes the result to rd and returns it on a
// valid/ready response channel.
//   clk, reset_n                 clock / async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_op/req_rd/req_rs1/rs2    operation and register addresses
//   wr_en/wr_addr/wr_data        host preload, honoured only in IDLE
//   ULAControl/scrA/scrB         registered drive into the ula
//   ULAResult/Z                  ula outputs
//   rsp_valid/rsp_ready          response handshake
//   rsp_result/rsp_zero/rsp_err  captured result, zero flag, illegal-op flag
// Build option: define ULA_SEQ_OPCHECK_EN to reject ops the ula does not
// implement (rsp_err=1, no ula drive, no writeback). Without it every
// 3-bit op is forwarded and rsp_err is tied 0.
// ---------------------------------------------------------------------------
module ula_op_sequencer
    import ula_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREGS  = 8,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [2:0]        ULAControl,
    output logic [DATA_W-1:0] scrA,
    output logic [DATA_W-1:0] scrB,
    input  logic [DATA_W-1:0] ULAResult,
    input  logic              Z,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err
);

    seq_state_t        state;
    logic [ADDR_W-1:0] rd_q;
    logic [DATA_W-1:0] rd1_data;
    logic [DATA_W-1:0] rd2_data;
    logic              wb_en;
    logic              pl_en;
    logic              op_bad;

    // Operand reads are asynchronous, so a preload in the same IDLE cycle
    // as an accept is not yet visible: operands come from pre-write data.
    assign pl_en = wr_en && (state == IDLE);
    assign wb_en = (state == EXEC) && !op_bad;

    ula_seq_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd1_addr (req_rs1),
        .rd1_data (rd1_data),
        .rd2_addr (req_rs2),
        .rd2_data (rd2_data),
        .wb_en    (wb_en),
        .wb_addr  (rd_q),
        .wb_data  (ULAResult),
        .pl_en    (pl_en),
        .pl_addr  (wr_addr),
        .pl_data  (wr_data)
    );

`ifdef ULA_SEQ_OPCHECK_EN
    logic op_bad_q;
    assign op_bad = op_bad_q;
`else
    assign op_bad  = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rd_q       <= '0;
            ULAControl <= '0;
            scrA       <= '0;
            scrB       <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
`ifdef ULA_SEQ_OPCHECK_EN
            op_bad_q   <= 1'b0;
            rsp_err    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rd_q      <= req_rd;
                        req_ready <= 1'b0;
                        state     <= EXEC;
`ifdef ULA_SEQ_OPCHECK_EN
                        // Illegal ops leave the ula drive untouched but still
                        // pass through EXEC so latency matches legal ops.
                        if (is_legal_op(ula_op_t'(req_op))) begin
                            ULAControl <= req_op;
                            scrA       <= rd1_data;
                            scrB       <= rd2_data;
                            op_bad_q   <= 1'b0;
                        end else begin
                            op_bad_q   <= 1'b1;
                        end
`else
                        ULAControl <= req_op;
                        scrA       <= rd1_data;
                        scrB       <= rd2_data;
`endif
                    end
                end
                EXEC: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`ifdef ULA_SEQ_OPCHECK_EN
                    if (op_bad_q) begin
                        rsp_result <= '0;
                        rsp_zero   <= 1'b0;
                        rsp_err    <= 1'b1;
                    end else begin
                        rsp_result <= ULAResult;
                        rsp_zero   <= Z;
                        rsp_err    <= 1'b0;
                    end
`else
                    rsp_result <= ULAResult;
                    rsp_zero   <= Z;
`endif
                end
                RESP: begin
                    // No same-cycle re-accept: the next request is taken from IDLE.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ula_op_sequencer
// Directed bench for ula_op_sequencer with a small combinational ula model.
// ---------------------------------------------------------------------------
module tb_ula_op_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready;
    logic [2:0] req_op, req_rd, req_rs1, req_rs2;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] ULAControl;
    logic [7:0] scrA, scrB, ULAResult;
    logic       Z;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_zero, rsp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ula_op_sequencer #(.DATA_W(8), .NREGS(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ULAControl(ULAControl), .scrA(scrA), .scrB(scrB),
        .ULAResult(ULAResult), .Z(Z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    // External ula model
    always_comb begin
        case (ULAControl)
            3'b000:  ULAResult = scrA + scrB;
            3'b001:  ULAResult = scrA - scrB;
            3'b010:  ULAResult = scrA & scrB;
            3'b011:  ULAResult = scrA | scrB;
            3'b101:  ULAResult = (scrA < scrB) ? 8'd1 : 8'd0;
            default: ULAResult = 8'd0;
        endcase
    end
    assign Z = (ULAResult == 8'd0);

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Request presented after edge N; v1 = rsp_valid after N+1, v2 after N+2.
    task automatic run_op(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic we, input logic [2:0] wa,
                          input logic [7:0] wd, output logic v1, output logic v2,
                          output logic [7:0] res, output logic z, output logic e);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        wr_en = we; wr_addr = wa; wr_data = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; wr_en = 1'b0;
        v1 = rsp_valid;
        @(posedge clk); #1;
        v2 = rsp_valid;
        n = 0;
        while (!rsp_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        if (rsp_valid) begin
            res = rsp_result; z = rsp_zero; e = rsp_err;
            rsp_ready = 1'b1;
            @(posedge clk); #1;
            rsp_ready = 1'b0;
        end else begin
            res = 'x; z = 1'bx; e = 1'bx;
        end
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [7:0] val);
        logic v1, v2, z, e;
        run_op(3'b000, 3'd0, a, 3'd0, 1'b0, 3'd0, 8'd0, v1, v2, val, z, e);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({ULAControl, scrA, scrB} !== 19'd0) begin errors++; $display("FAIL reset_ula_drive got=%h/%h/%h exp=0", ULAControl, scrA, scrB); end
        checks++; if ({rsp_result, rsp_zero, rsp_err} !== 10'd0) begin errors++; $display("FAIL reset_rsp got=%h/%b/%b exp=0", rsp_result, rsp_zero, rsp_err); end
    endtask

    task automatic test_basic_ops();
        logic [2:0] ops  [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
        logic [7:0] eres [5] = '{8'd5, 8'd1, 8'd2, 8'd3, 8'd0};
        logic       ez   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic v1, v2, z, e;
        logic [7:0] res, rb;
        preload(3'd1, 8'd3);
        preload(3'd2, 8'd2);
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 8'd0, v1, v2, res, z, e);
            checks++; if ({v1, v2} !== 2'b01) begin errors++; $display("FAIL basic_latency op=%b got=%b%b exp=01", ops[i], v1, v2); end
            checks++; if (res !== eres[i]) begin errors++; $display("FAIL basic_result op=%b got=%h exp=%h", ops[i], res, eres[i]); end
            checks++; if ({z, e} !== {ez[i], 1'b0}) begin errors++; $display("FAIL basic_flags op=%b got=%b%b exp=%b0", ops[i], z, e, ez[i]); end
            read_reg(3'd3, rb);
            checks++; if (rb !== eres[i]) begin errors++; $display("FAIL basic_r3 op=%b got=%h exp=%h", ops[i], rb, eres[i]); end
        end
    endtask

    task automatic test_r0_and_hazards();
        logic v1, v2, z, e;
        logic [7:0] res, rb;
        run_op(3'b000, 3'd0, 3'd1, 3'd2, 1'b0, 3'd0, 8'd0, v1, v2, res, z, e);
        checks++; if (res !== 8'd5) begin errors++; $display("FAIL r0_add_result got=%h exp=05", res); end
        read_reg(3'd0, rb);
        checks++; if (rb !== 8'd0) begin errors++; $display("FAIL r0_after_wb got=%h exp=00", rb); end
        preload(3'd0, 8'h77);
        read_reg(3'd0, rb);
        checks++; if (rb !== 8'd0) begin errors++; $display("FAIL r0_after_preload got=%h exp=00", rb); end
        // preload attempted while in EXEC
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'b000; req_rd = 3'd0; req_rs1 = 3'd1; req_rs2 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0; wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hAA;
        @(posedge clk); #1;
        wr_en = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        read_reg(3'd5, rb);
        checks++; if (rb !== 8'd0) begin errors++; $display("FAIL exec_preload_r5 got=%h exp=00", rb); end
        // preload and accept in the same cycle: operand is pre-write value
        run_op(3'b000, 3'd0, 3'd7, 3'd0, 1'b1, 3'd7, 8'h12, v1, v2, res, z, e);
        checks++; if (res !== 8'd0) begin errors++; $display("FAIL same_cycle_operand got=%h exp=00", res); end
        read_reg(3'd7, rb);
        checks++; if (rb !== 8'h12) begin errors++; $display("FAIL same_cycle_write got=%h exp=12", rb); end
        // rd == rs1 == rs2
        run_op(3'b000, 3'd1, 3'd1, 3'd1, 1'b0, 3'd0, 8'd0, v1, v2, res, z, e);
        checks++; if (res !== 8'd6) begin errors++; $display("FAIL rd_eq_rs_result got=%h exp=06", res); end
        read_reg(3'd1, rb);
        checks++; if (rb !== 8'd6) begin errors++; $display("FAIL rd_eq_rs_r1 got=%h exp=06", rb); end
    endtask

    task automatic test_wrap();
        logic v1, v2, z, e;
        logic [7:0] res;
        preload(3'd1, 8'd4);
        preload(3'd2, 8'd5);
        run_op(3'b001, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 8'd0, v1, v2, res, z, e);
        checks++; if ({res, z} !== {8'hFF, 1'b0}) begin errors++; $display("FAIL wrap_sub got=%h/%b exp=ff/0", res, z); end
        run_op(3'b101, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 8'd0, v1, v2, res, z, e);
        checks++; if ({res, z} !== {8'h01, 1'b0}) begin errors++; $display("FAIL wrap_slt got=%h/%b exp=01/0", res, z); end
        run_op(3'b000, 3'd0, 3'd4, 3'd0, 1'b0, 3'd0, 8'd0, v1, v2, res, z, e);
        checks++; if (res !== 8'h01) begin errors++; $display("FAIL wrap_readback_r4 got=%h exp=01", res); end
    endtask

    task automatic test_backpressure();
        logic [7:0] rb;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'b000; req_rd = 3'd3; req_rs1 = 3'd1; req_rs2 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'b001; req_rd = 3'd6;
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({rsp_valid, rsp_result, req_ready} !== {1'b1, 8'd9, 1'b0}) begin
                errors++;
                $display("FAIL stall_cycle%0d got=v%b r%h rdy%b exp=v1 r09 rdy0", i, rsp_valid, rsp_result, req_ready);
            end
        end
        req_valid = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stall_no_extra_rsp got=%b exp=0", rsp_valid); end
        end
        read_reg(3'd6, rb);
        checks++; if (rb !== 8'd0) begin errors++; $display("FAIL stall_preload_dropped got=%h exp=00", rb); end
        read_reg(3'd3, rb);
        checks++; if (rb !== 8'd9) begin errors++; $display("FAIL stall_r3 got=%h exp=09", rb); end
    endtask

    task automatic test_illegal_op();
        logic v1, v2, z, e;
        logic [7:0] res, rb;
        run_op(3'b111, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 8'd0, v1, v2, res, z, e);
        checks++; if ({v1, v2} !== 2'b01) begin errors++; $display("FAIL illegal_latency got=%b%b exp=01", v1, v2); end
`ifdef ULA_SEQ_OPCHECK_EN
        checks++; if ({e, res, z} !== {1'b1, 8'd0, 1'b0}) begin errors++; $display("FAIL illegal_rsp got=e%b r%h z%b exp=e1 r00 z0", e, res, z); end
        checks++; if (ULAControl !== 3'b000) begin errors++; $display("FAIL illegal_not_driven got=%b exp=000", ULAControl); end
        read_reg(3'd3, rb);
        checks++; if (rb !== 8'd9) begin errors++; $display("FAIL illegal_rd_kept got=%h exp=09", rb); end
`else
        checks++; if ({e, res, z} !== {1'b0, 8'd0, 1'b1}) begin errors++; $display("FAIL illegal_rsp got=e%b r%h z%b exp=e0 r00 z1", e, res, z); end
        checks++; if (ULAControl !== 3'b111) begin errors++; $display("FAIL illegal_forwarded got=%b exp=111", ULAControl); end
        read_reg(3'd3, rb);
        checks++; if (rb !== 8'd0) begin errors++; $display("FAIL illegal_rd_written got=%h exp=00", rb); end
`endif
    endtask

    task automatic test_reset_mid();
        logic [7:0] rb;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 3'b000; req_rd = 3'd3; req_rs1 = 3'd1; req_rs2 = 3'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if ({scrA, scrB} !== {8'd4, 8'd5}) begin errors++; $display("FAIL mid_exec_operands got=%h/%h exp=04/05", scrA, scrB); end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, ULAControl, scrA, scrB, rsp_result} !== 28'd0) begin
            errors++;
            $display("FAIL mid_reset_async got=v%b c%b a%h b%h r%h exp=0", rsp_valid, ULAControl, scrA, scrB, rsp_result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_no_rsp got=%b exp=0", rsp_valid); end
        end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got=%b exp=1", req_ready); end
        read_reg(3'd1, rb);
        checks++; if (rb !== 8'd0) begin errors++; $display("FAIL mid_reset_r1 got=%h exp=00", rb); end
        read_reg(3'd3, rb);
        checks++; if (rb !== 8'd0) begin errors++; $display("FAIL mid_reset_r3 got=%h exp=00", rb); end
    endtask

    initial begin
        reset_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;
        test_reset();
        test_basic_ops();
        test_r0_and_hazards();
        test_wrap();
        test_backpressure();
        test_illegal_op();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
